regbank_writeback: RTL and testbench



---
 rtl/regwb_pkg.sv | 17 +
 rtl/regwb_fifo.sv | 70 +++++++
 rtl/regbank_writeback.sv | 129 ++++++++++++
 tb/tb_regbank_writeback.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-bank writeback front end.
package regwb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hardwired, so writes to it are dropped before queueing.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// In-order FIFO of writeback entries, with an oldest-first view of its
// contents for the bypass search.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output wb_entry_t        entries_o [DEPTH]
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count decide which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/regbank_writeback.sv
// Writeback front end: ALU/memory arbitration, in-order buffering and a
// registered bank write port. Optional bypass search under REGWB_BYPASS_EN.
module regbank_writeback
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    input  logic                     wb_stall,
    output logic [ADDR_W-1:0]        addr_d,
    output logic [DATA_W-1:0]        data,
    output logic                     write,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     empty,
    input  logic [ADDR_W-1:0]        byp_addr,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        push_entry, fifo_head;
    wb_entry_t        fifo_entries [DEPTH];
    logic             fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0] fifo_count;

    logic              write_q, write_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    assign alu_ready = !fifo_full;
    assign mem_ready = !fifo_full && !alu_valid;

    // Register-0 requests handshake normally but never reach the FIFO.
    always_comb begin
        push       = 1'b0;
        push_entry = '{addr: alu_addr, data: alu_data};
        if (alu_valid && alu_ready) begin
            push = !is_zero_reg(alu_addr);
        end else if (mem_valid && mem_ready) begin
            push       = !is_zero_reg(mem_addr);
            push_entry = '{addr: mem_addr, data: mem_data};
        end
    end

    assign pop = !fifo_empty && !wb_stall;

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .entries_o    (fifo_entries)
    );

    always_comb begin
        write_d   = pop;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_addr_d = fifo_head.addr;
            wb_data_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            write_q   <= write_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign write   = write_q;
    assign addr_d  = wb_addr_q;
    assign data    = wb_data_q;
    assign pending = fifo_count;
    assign empty   = fifo_empty && !write_q;

`ifdef REGWB_BYPASS_EN
    // Lowest priority first: the in-flight bank write, then FIFO oldest to youngest.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (write_q && wb_addr_q == byp_addr) begin
            byp_hit  = 1'b1;
            byp_data = wb_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < fifo_count && fifo_entries[i].addr == byp_addr) begin
                byp_hit  = 1'b1;
                byp_data = fifo_entries[i].data;
            end
        end
        if (is_zero_reg(byp_addr)) begin
            byp_hit  = 1'b0;
            byp_data = '0;
        end
    end
`else
    wb_entry_t unused_entries [DEPTH];
    logic      unused_byp;
    assign unused_entries = fifo_entries;
    assign unused_byp     = ^byp_addr;
    assign byp_hit        = 1'b0;
    assign byp_data       = '0;
`endif

endmodule

// File: tb/tb_regbank_writeback.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback front end.
module tb_regbank_writeback;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0, mem_valid = 1'b0, wb_stall = 1'b0;
    logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0, byp_addr = '0;
    logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
    logic              alu_ready, mem_ready, write, empty, byp_hit;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data, byp_data;
    logic [$clog2(DEPTH):0] pending;

    regbank_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wb_stall  (wb_stall),
        .addr_d    (addr_d),
        .data      (data),
        .write     (write),
        .pending   (pending),
        .empty     (empty),
        .byp_addr  (byp_addr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              q[$];
    logic              exp_write = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest queued match wins, else the in-flight bank write.
    function automatic void byp_model(input logic [ADDR_W-1:0] ba, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef REGWB_BYPASS_EN
        if (ba != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].addr == ba) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
            if (!hit && exp_write && exp_addr == ba) begin
                hit = 1'b1;
                d   = exp_data;
            end
        end
`endif
    endfunction

    task automatic check_regs();
        check("write", write, exp_write);
        check("addr_d", addr_d, exp_addr);
        check("data", data, exp_data);
        check("pending", pending, q.size());
        check("empty", empty, (q.size() == 0) && !exp_write);
        check("no_write_r0", write && addr_d == 0, 0);
    endtask

    // Called at a falling edge; drives one cycle of stimulus and checks both
    // the combinational outputs and the registered results after the edge.
    task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                         input logic st, input logic [ADDR_W-1:0] ba);
        logic              exp_ar, exp_mr, eh;
        logic [DATA_W-1:0] ed;
        req_t              e;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        wb_stall  = st; byp_addr = ba;
        #1;
        exp_ar = q.size() < DEPTH;
        exp_mr = exp_ar && !av;
        check("alu_ready", alu_ready, exp_ar);
        check("mem_ready", mem_ready, exp_mr);
        byp_model(ba, eh, ed);
        check("byp_hit", byp_hit, eh);
        check("byp_data", byp_data, ed);
        if (q.size() > 0 && !st) begin
            e         = q.pop_front();
            exp_write = 1'b1;
            exp_addr  = e.addr;
            exp_data  = e.data;
        end else begin
            exp_write = 1'b0;
        end
        if (av && exp_ar) begin
            if (aa != 0) q.push_back('{aa, ad});
        end else if (mv && exp_mr && ma != 0) begin
            q.push_back('{ma, md});
        end
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, st, '0);
    endtask

    task automatic async_reset();
        alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0; byp_addr = 5'd7;
        #2 rst_n = 1'b0;
        #1;
        check("rst_write", write, 0);
        check("rst_addr_d", addr_d, 0);
        check("rst_data", data, 0);
        check("rst_pending", pending, 0);
        check("rst_empty", empty, 1);
        check("rst_byp_hit", byp_hit, 0);
        check("rst_byp_data", byp_data, 0);
        q.delete();
        exp_write = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_regs();
        check("reset_byp_hit", byp_hit, 0);

        // Single ALU write: bank write one cycle after the second edge.
        cycle(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b0, '0);
        check("t1_write_early", write, 0);
        idle(1'b0);
        check("t1_write", write, 1);
        check("t1_addr", addr_d, 3);
        check("t1_data", data, 32'h11);
        idle(1'b0);
        check("t1_write_end", write, 0);
        check("t1_empty", empty, 1);

        // Both sources valid: ALU first, memory on the following cycle.
        cycle(1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 5'd6, 32'hB, 1'b0, '0);
        check("t2_first", addr_d, 5);
        idle(1'b0);
        check("t2_second", addr_d, 6);
        check("t2_second_wr", write, 1);
        idle(1'b0);

        // Stall and fill, then drain in order.
        for (int i = 1; i <= DEPTH; i++)
            cycle(1'b1, ADDR_W'(i), 32'h100 + i, 1'b0, '0, '0, 1'b1, '0);
        check("t3_full_pending", pending, DEPTH);
        cycle(1'b1, 5'd9, 32'h9, 1'b1, 5'd9, 32'h9, 1'b1, '0);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(1'b0);
            check("t3_drain_addr", addr_d, i);
        end
        idle(1'b0);
        check("t3_pending_end", pending, 0);

        // Register 0 request: handshake only.
        cycle(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, 1'b0, '0);
        check("t4_pending", pending, 0);
        idle(1'b0);
        check("t4_no_write", write, 0);

        // Bypass: two writes to r7 queued behind a stall.
        cycle(1'b1, 5'd7, 32'd1, 1'b0, '0, '0, 1'b1, '0);
        cycle(1'b1, 5'd7, 32'd2, 1'b0, '0, '0, 1'b1, '0);
        byp_addr = 5'd7;
        #1;
`ifdef REGWB_BYPASS_EN
        check("t5_hit7", byp_hit, 1);
        check("t5_data7", byp_data, 2);
`else
        check("t5_hit7", byp_hit, 0);
        check("t5_data7", byp_data, 0);
`endif
        byp_addr = 5'd8;
        #1;
        check("t5_hit8", byp_hit, 0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);

        // Asynchronous reset with three entries pending.
        cycle(1'b1, 5'd9, 32'd3, 1'b0, '0, '0, 1'b1, '0);
        check("t6_pending3", pending, 3);
        async_reset();
        repeat (3) idle(1'b0);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 701 == 700) begin
                async_reset();
            end else begin
                cycle(($urandom % 3) == 0, ADDR_W'($urandom % 8), $urandom,
                      ($urandom % 2) == 0, ADDR_W'($urandom % 8), $urandom,
                      ($urandom % 4) == 0, ADDR_W'($urandom % 8));
            end
        end
        repeat (DEPTH + 2) idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
